ddr_burst_engine: RTL and testbench

- Responder side of the rd/wr burst handshake issued by the DDR top-level arbiter.
- Accepts one read or write burst at a time, chops it into local-interface transactions of up to LOCAL_BURST beats and drives the DDR2 controller IP's local port.
- Returns read data, requests write data, pulses the address-update strobes and signals burst completion.

---
 rtl/ddr_burst_engine.sv | 204 ++++++++++++++++++++
 tb/tb_ddr_burst_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_engine.sv
// ddr_burst_engine: chops rd/wr bursts into DDR2 local-port transactions of up to LOCAL_BURST beats.
// Define READ_TIMEOUT_EN to add the sticky rd_timeout read watchdog.
module ddr_burst_engine #(
  parameter int MEM_DATA_BITS  = 32,
  parameter int ADDR_BITS      = 25,
  parameter int LOCAL_BURST    = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       mem_clk,
  input  logic                       rst,
  input  logic                       rd_burst_req,
  input  logic                       wr_burst_req,
  input  logic [9:0]                 rd_burst_len,
  input  logic [9:0]                 wr_burst_len,
  input  logic [ADDR_BITS-1:0]       rd_burst_addr,
  input  logic [ADDR_BITS-1:0]       wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0]   wr_burst_data,
  output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
  output logic                       rd_burst_data_valid,
  output logic                       wr_burst_data_req,
  output logic                       rd_burst_finish,
  output logic                       wr_burst_finish,
  output logic                       rd_addr_up,
  output logic                       wr_addr_up,
`ifdef READ_TIMEOUT_EN
  output logic                       rd_timeout,
`endif
  input  logic                       local_init_done,
  input  logic                       local_ready,
  input  logic [MEM_DATA_BITS-1:0]   local_rdata,
  input  logic                       local_rdata_valid,
  output logic [ADDR_BITS-1:0]       local_address,
  output logic                       local_write_req,
  output logic                       local_read_req,
  output logic                       local_burstbegin,
  output logic [MEM_DATA_BITS-1:0]   local_wdata,
  output logic [MEM_DATA_BITS/8-1:0] local_be,
  output logic [2:0]                 local_size
);

  if (!(LOCAL_BURST == 1 || LOCAL_BURST == 2 || LOCAL_BURST == 4) || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ddr_burst_engine: LOCAL_BURST must be 1, 2 or 4 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, FIN_WR, FIN_RD} state_t;

  state_t      state;
  logic [9:0]  len_r;
  logic [9:0]  beats_left;
  logic [2:0]  chunk_left;
  logic [9:0]  rcv_cnt;
  logic        first_done;

`ifdef READ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  function automatic logic [2:0] chunk_of(input logic [9:0] n);
    if (n >= 10'(LOCAL_BURST)) return 3'(LOCAL_BURST);
    return n[2:0];
  endfunction

  assign wr_burst_data_req   = local_write_req & local_ready;
  assign local_wdata         = wr_burst_data;
  assign rd_burst_data       = local_rdata;
  assign rd_burst_data_valid = local_rdata_valid & (state == READ);
  assign local_be            = '1;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      local_address    <= '0;
      local_size       <= '0;
      local_write_req  <= 1'b0;
      local_read_req   <= 1'b0;
      local_burstbegin <= 1'b0;
      rd_burst_finish  <= 1'b0;
      wr_burst_finish  <= 1'b0;
      rd_addr_up       <= 1'b0;
      wr_addr_up       <= 1'b0;
      len_r            <= '0;
      beats_left       <= '0;
      chunk_left       <= '0;
      rcv_cnt          <= '0;
      first_done       <= 1'b0;
`ifdef READ_TIMEOUT_EN
      to_cnt           <= '0;
      rd_timeout       <= 1'b0;
`endif
    end else begin
      rd_burst_finish <= 1'b0;
      wr_burst_finish <= 1'b0;
      rd_addr_up      <= 1'b0;
      wr_addr_up      <= 1'b0;
      // Loss of calibration abandons the burst silently; the requester must retry.
      if ((state == WRITE || state == READ) && !local_init_done) begin
        state            <= IDLE;
        local_write_req  <= 1'b0;
        local_read_req   <= 1'b0;
        local_burstbegin <= 1'b0;
        beats_left       <= '0;
        chunk_left       <= '0;
        rcv_cnt          <= '0;
        first_done       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (local_init_done && wr_burst_req) begin
              local_address    <= wr_burst_addr;
              local_size       <= chunk_of(wr_burst_len);
              len_r            <= wr_burst_len;
              beats_left       <= wr_burst_len;
              chunk_left       <= chunk_of(wr_burst_len);
              first_done       <= 1'b0;
              local_write_req  <= (wr_burst_len != 10'd0);
              local_burstbegin <= (wr_burst_len != 10'd0);
              wr_burst_finish  <= (wr_burst_len == 10'd0);
              state            <= (wr_burst_len == 10'd0) ? FIN_WR : WRITE;
            end else if (local_init_done && rd_burst_req) begin
              local_address    <= rd_burst_addr;
              local_size       <= chunk_of(rd_burst_len);
              len_r            <= rd_burst_len;
              beats_left       <= rd_burst_len;
              rcv_cnt          <= '0;
              first_done       <= 1'b0;
              local_read_req   <= (rd_burst_len != 10'd0);
              local_burstbegin <= (rd_burst_len != 10'd0);
              rd_burst_finish  <= (rd_burst_len == 10'd0);
              state            <= (rd_burst_len == 10'd0) ? FIN_RD : READ;
`ifdef READ_TIMEOUT_EN
              to_cnt           <= '0;
`endif
            end
          end
          WRITE: begin
            if (wr_burst_data_req) begin
              local_burstbegin <= 1'b0;
              beats_left       <= beats_left - 10'd1;
              chunk_left       <= chunk_left - 3'd1;
              if (!first_done) begin
                wr_addr_up <= 1'b1;
                first_done <= 1'b1;
              end
              if (beats_left == 10'd1) begin
                local_write_req <= 1'b0;
                wr_burst_finish <= 1'b1;
                state           <= FIN_WR;
              end else if (chunk_left == 3'd1) begin
                local_address    <= local_address + ADDR_BITS'(local_size);
                local_size       <= chunk_of(beats_left - 10'd1);
                chunk_left       <= chunk_of(beats_left - 10'd1);
                local_burstbegin <= 1'b1;
              end
            end
          end
          READ: begin
            // Command issue runs ahead of data return; beats_left counts beats not yet requested.
            if (local_read_req && local_ready) begin
              beats_left <= beats_left - 10'(local_size);
              if (!first_done) begin
                rd_addr_up <= 1'b1;
                first_done <= 1'b1;
              end
              if (beats_left == 10'(local_size)) begin
                local_read_req   <= 1'b0;
                local_burstbegin <= 1'b0;
              end else begin
                local_address <= local_address + ADDR_BITS'(local_size);
                local_size    <= chunk_of(beats_left - 10'(local_size));
              end
            end
            if (local_rdata_valid) begin
              rcv_cnt <= rcv_cnt + 10'd1;
              if ((rcv_cnt + 10'd1) == len_r) begin
                local_read_req   <= 1'b0;
                local_burstbegin <= 1'b0;
                rd_burst_finish  <= 1'b1;
                state            <= FIN_RD;
              end
            end
`ifdef READ_TIMEOUT_EN
            if (local_rdata_valid) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              to_cnt           <= '0;
              rd_timeout       <= 1'b1;
              local_read_req   <= 1'b0;
              local_burstbegin <= 1'b0;
              rd_burst_finish  <= 1'b1;
              state            <= FIN_RD;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
`endif
          end
          FIN_WR, FIN_RD: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_engine.sv
// Randomized bench for ddr_burst_engine: queue-based burst chopping model plus a latency controller model.
`timescale 1ns/1ps
module tb_ddr_burst_engine;
  localparam int DW = 32;
  localparam int AW = 25;
  localparam int LB = 4;
  localparam int TO = 16;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_burst_req = 1'b0;
  logic          wr_burst_req = 1'b0;
  logic [9:0]    rd_burst_len = '0;
  logic [9:0]    wr_burst_len = '0;
  logic [AW-1:0] rd_burst_addr = '0;
  logic [AW-1:0] wr_burst_addr = '0;
  logic [DW-1:0] wr_burst_data = '0;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_data_valid, wr_burst_data_req;
  logic          rd_burst_finish, wr_burst_finish, rd_addr_up, wr_addr_up;
  logic          local_init_done = 1'b0;
  logic          local_ready = 1'b0;
  logic [DW-1:0] local_rdata = '0;
  logic          local_rdata_valid = 1'b0;
  logic [AW-1:0] local_address;
  logic          local_write_req, local_read_req, local_burstbegin;
  logic [DW-1:0] local_wdata;
  logic [DW/8-1:0] local_be;
  logic [2:0]    local_size;
`ifdef READ_TIMEOUT_EN
  logic          rd_timeout;
`endif

  always #5 mem_clk = ~mem_clk;

  ddr_burst_engine #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LOCAL_BURST(LB), .TIMEOUT_CYCLES(TO)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .rd_burst_data(rd_burst_data),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .rd_addr_up(rd_addr_up), .wr_addr_up(wr_addr_up),
`ifdef READ_TIMEOUT_EN
    .rd_timeout(rd_timeout),
`endif
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .local_address(local_address), .local_write_req(local_write_req),
    .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
    .local_wdata(local_wdata), .local_be(local_be), .local_size(local_size)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {7'h5A, a} ^ 32'h0013_37C5;
  endfunction

  function automatic logic [31:0] enc(input logic [AW-1:0] a, input logic [2:0] s);
    return {4'(s), 3'b000, a};
  endfunction

  int            cyc = 0;
  int            ready_mode = 0;
  int            rd_lat = 5;
  bit            ctrl_mute = 1'b0;
  logic [AW-1:0] rq_addr[$];
  int            rq_due[$];
  logic [DW-1:0] wfifo[$];

  logic [31:0]   exp_wtxn[$], exp_rtxn[$], obs_wtxn[$], obs_rtxn[$];
  logic [DW-1:0] exp_wdata[$], exp_rdata[$], obs_wdata[$], obs_rdata[$];
  int wup, rup, wfin, rfin, wfin_cyc, rfin_cyc, last_wbeat, last_rvld, first_rreq_cyc;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_size;

  always @(posedge mem_clk) cyc <= cyc + 1;

  // Controller model: ready pattern and fixed-latency read return in command order.
  always @(posedge mem_clk) begin
    #1;
    case (ready_mode)
      0: local_ready = 1'b1;
      1: local_ready = ~local_ready;
      default: local_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      local_rdata_valid = 1'b1;
      local_rdata = mem_word(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      local_rdata_valid = 1'b0;
      local_rdata = $urandom;
    end
  end

  // Show-ahead write FIFO.
  always @(posedge mem_clk) begin
    if (wr_burst_data_req && wfifo.size() > 0) void'(wfifo.pop_front());
    wr_burst_data = (wfifo.size() > 0) ? wfifo[0] : '0;
  end

  always @(negedge mem_clk) begin
    if (!rst) begin
      if (wr_burst_data_req) begin
        obs_wdata.push_back(local_wdata);
        last_wbeat = cyc;
        if (local_burstbegin) obs_wtxn.push_back(enc(local_address, local_size));
      end
      if (local_read_req && local_ready) begin
        check("rd_cmd_burstbegin", 64'(local_burstbegin), 64'd1);
        obs_rtxn.push_back(enc(local_address, local_size));
        if (!ctrl_mute)
          for (int i = 0; i < int'(local_size); i++) begin
            rq_addr.push_back(local_address + AW'(i));
            rq_due.push_back(cyc + rd_lat);
          end
      end
      if (local_read_req && first_rreq_cyc < 0) first_rreq_cyc = cyc;
      if (rd_burst_data_valid) begin
        obs_rdata.push_back(rd_burst_data);
        last_rvld = cyc;
      end
      if (wr_addr_up) wup++;
      if (rd_addr_up) rup++;
      if (wr_burst_finish) begin wfin++; wfin_cyc = cyc; end
      if (rd_burst_finish) begin rfin++; rfin_cyc = cyc; end
      if (prev_hold && (local_write_req || local_read_req)) begin
        check("addr_hold", 64'(local_address), 64'(prev_addr));
        check("size_hold", 64'(local_size), 64'(prev_size));
      end
      prev_hold = (local_write_req || local_read_req) && !local_ready;
      prev_addr = local_address;
      prev_size = local_size;
    end
  end

  task automatic model_chunks(input bit is_rd, input logic [AW-1:0] a, input int len);
    logic [AW-1:0] base;
    int rem, sz;
    base = a;
    rem = len;
    while (rem > 0) begin
      sz = (rem < LB) ? rem : LB;
      if (is_rd) exp_rtxn.push_back(enc(base, 3'(sz)));
      else       exp_wtxn.push_back(enc(base, 3'(sz)));
      base = base + AW'(sz);
      rem -= sz;
    end
  endtask

  task automatic clear_obs();
    exp_wtxn.delete(); exp_rtxn.delete(); obs_wtxn.delete(); obs_rtxn.delete();
    exp_wdata.delete(); exp_rdata.delete(); obs_wdata.delete(); obs_rdata.delete();
    wfifo.delete();
    wup = 0; rup = 0; wfin = 0; rfin = 0; wfin_cyc = 0; rfin_cyc = 0;
    last_wbeat = 0; last_rvld = 0; first_rreq_cyc = -1;
  endtask

  task automatic run(input bit dw, input logic [AW-1:0] wa, input int wl,
                     input bit dr, input logic [AW-1:0] ra, input int rl);
    int n;
    logic [DW-1:0] d;
    clear_obs();
    if (dw) begin
      model_chunks(1'b0, wa, wl);
      for (int i = 0; i < wl; i++) begin
        d = $urandom;
        wfifo.push_back(d);
        exp_wdata.push_back(d);
      end
    end
    if (dr) begin
      model_chunks(1'b1, ra, rl);
      for (int i = 0; i < rl; i++) exp_rdata.push_back(mem_word(ra + AW'(i)));
    end
    wr_burst_addr = wa; wr_burst_len = 10'(wl);
    rd_burst_addr = ra; rd_burst_len = 10'(rl);
    wr_burst_req = dw; rd_burst_req = dr;
    n = 0;
    while (((dw && wfin == 0) || (dr && rfin == 0)) && n < 3000) begin
      @(negedge mem_clk); #1;
      n++;
      if (obs_wdata.size() > 0 || wfin > 0) wr_burst_req = 1'b0;
      if (obs_rdata.size() > 0 || rfin > 0) rd_burst_req = 1'b0;
    end
    wr_burst_req = 1'b0; rd_burst_req = 1'b0;
    check("burst_done_in_budget", 64'(n < 3000), 64'd1);
    repeat (4) @(negedge mem_clk);
    #1;
    if (dw) begin
      check("wr_txn_count", 64'(obs_wtxn.size()), 64'(exp_wtxn.size()));
      for (int i = 0; i < exp_wtxn.size(); i++)
        if (i < obs_wtxn.size()) check("wr_txn", 64'(obs_wtxn[i]), 64'(exp_wtxn[i]));
      check("wr_req_count", 64'(obs_wdata.size()), 64'(wl));
      for (int i = 0; i < exp_wdata.size(); i++)
        if (i < obs_wdata.size()) check("wr_data", 64'(obs_wdata[i]), 64'(exp_wdata[i]));
      check("wr_addr_up_count", 64'(wup), 64'(wl > 0));
      check("wr_finish_count", 64'(wfin), 64'd1);
      if (wl > 0) check("wr_finish_cycle", 64'(wfin_cyc), 64'(last_wbeat + 1));
    end
    if (dr) begin
      check("rd_txn_count", 64'(obs_rtxn.size()), 64'(exp_rtxn.size()));
      for (int i = 0; i < exp_rtxn.size(); i++)
        if (i < obs_rtxn.size()) check("rd_txn", 64'(obs_rtxn[i]), 64'(exp_rtxn[i]));
      check("rd_valid_count", 64'(obs_rdata.size()), 64'(rl));
      for (int i = 0; i < exp_rdata.size(); i++)
        if (i < obs_rdata.size()) check("rd_data", 64'(obs_rdata[i]), 64'(exp_rdata[i]));
      check("rd_addr_up_count", 64'(rup), 64'(rl > 0));
      check("rd_finish_count", 64'(rfin), 64'd1);
      if (rl > 0) check("rd_finish_cycle", 64'(rfin_cyc), 64'(last_rvld + 1));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, op, wl, rl;
    logic [AW-1:0] wa, ra;
    clear_obs();
    repeat (3) @(negedge mem_clk);
    check("rst_write_req", 64'(local_write_req), 64'd0);
    check("rst_read_req", 64'(local_read_req), 64'd0);
    check("rst_burstbegin", 64'(local_burstbegin), 64'd0);
    check("rst_finish", 64'({wr_burst_finish, rd_burst_finish}), 64'd0);
    check("rst_addr_up", 64'({wr_addr_up, rd_addr_up}), 64'd0);
    check("rst_address", 64'(local_address), 64'd0);
    check("rst_size", 64'(local_size), 64'd0);
    check("rst_data_req", 64'(wr_burst_data_req), 64'd0);
    check("local_be", 64'(local_be), 64'hF);
    rst = 1'b0;
    local_init_done = 1'b1;
    repeat (2) @(negedge mem_clk);
    #1;

    ready_mode = 0;
    run(1'b1, 25'h100, 4, 1'b0, '0, 0);
    ready_mode = 1;
    run(1'b1, 25'h1FFFFFE, 10, 1'b0, '0, 0);
    ready_mode = 0; rd_lat = 5;
    run(1'b0, '0, 0, 1'b1, 25'h20, 6);

    ready_mode = 2; rd_lat = 3;
    run(1'b1, 25'h40, 3, 1'b1, 25'h80, 5);
    check("rd_after_wr_finish", 64'(first_rreq_cyc), 64'(wfin_cyc + 2));

    ready_mode = 0;
    run(1'b1, 25'h500, 0, 1'b0, '0, 0);
    run(1'b0, '0, 0, 1'b1, 25'h600, 0);

    // Calibration loss during beat 2 of a len-4 write.
    clear_obs();
    for (int i = 0; i < 4; i++) wfifo.push_back($urandom);
    wr_burst_addr = 25'h300; wr_burst_len = 10'd4; wr_burst_req = 1'b1;
    n = 0;
    while (obs_wdata.size() < 2 && n < 100) begin
      @(negedge mem_clk); #1;
      n++;
      if (obs_wdata.size() > 0) wr_burst_req = 1'b0;
    end
    check("abort_reached_beat2", 64'(n < 100), 64'd1);
    local_init_done = 1'b0;
    @(negedge mem_clk); #1;
    check("abort_write_req_drop", 64'(local_write_req), 64'd0);
    repeat (5) @(negedge mem_clk);
    #1;
    check("abort_no_finish", 64'(wfin), 64'd0);
    check("abort_still_idle", 64'({local_write_req, local_read_req, local_burstbegin}), 64'd0);
    local_init_done = 1'b1;
    @(negedge mem_clk); #1;
    run(1'b1, 25'h340, 5, 1'b0, '0, 0);

    for (int k = 0; k < 24; k++) begin
      ready_mode = $urandom_range(0, 2);
      rd_lat = $urandom_range(1, 8);
      op = $urandom_range(0, 2);
      wl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      wa = AW'($urandom);
      ra = AW'($urandom);
      if ($urandom_range(0, 3) == 0) wa = '1 - AW'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) ra = '1 - AW'($urandom_range(0, 10));
      run(op != 1, wa, wl, op != 0, ra, rl);
    end

`ifdef READ_TIMEOUT_EN
    clear_obs();
    ready_mode = 0;
    ctrl_mute = 1'b1;
    rd_burst_addr = 25'h700; rd_burst_len = 10'd4; rd_burst_req = 1'b1;
    n = 0;
    while (rfin == 0 && n < 200) begin
      @(negedge mem_clk); #1;
      n++;
    end
    rd_burst_req = 1'b0;
    check("timeout_finish_seen", 64'(rfin), 64'd1);
    check("timeout_flag", 64'(rd_timeout), 64'd1);
    check("timeout_cycle", 64'(rfin_cyc), 64'(first_rreq_cyc + TO));
    repeat (4) @(negedge mem_clk);
    ctrl_mute = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
